mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Multicycle sequencer for the load/store phase of the CPU. After the main control unit decodes a memory instruction, this block drives the memory strobes, the memory data register load, the load-size and store-size unit controls, the MemoryData write-data mux select and the register-file write-back. Sub-word stores are handled as read-modify-write. The block sits beside the main control FSM: start/done handshake toward it, control strobes toward the datapath.

## Interface
- MEM_WAIT, 2, cycles mem_rd is held before read data is valid; legal range 1..15

- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- start  in  1  request pulse; accepted only in IDLE
- op  in  3  000 lw, 001 lh, 010 lb, 011 sw, 100 sh, 101 sb; 110/111 illegal
- addr_lo  in  2  byte-offset bits of the effective address
- mem_rd  out  1  memory read strobe
- mem_wr  out  1  memory write strobe
- mdr_ld  out  1  load memory data register
- reg_wr  out  1  register-file write enable for load write-back
- ls_ctrl  out  2  load-size select: 00 word, 01 half, 10 byte
- ss_ctrl  out  2  store-size select: 00 word, 01 half, 10 byte
- mux13_sel  out  2  MemoryData mux select: 00 store-size output, 01 ext16_32, 10 ulaResult; never 11
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle completion pulse
- misalign  out  1  alignment fault pulse, coincident with done

## Operation
- States: IDLE, RD, CAP, WB, WR, DONE.
- IDLE + start: op is latched and ls_ctrl/ss_ctrl are set from it. Both stay constant until return to IDLE.
- Transitions out of IDLE:
  - lw/lh/lb/sh/sb → RD
  - sw → WR
  - illegal op → DONE, with no memory activity
- RD: mem_rd=1. A wait counter runs 0..MEM_WAIT-1. At MEM_WAIT-1: loads → CAP; sh/sb → CAP.
- CAP: mdr_ld=1. Loads → WB; sh/sb → WR.
- WB: reg_wr=1 → DONE.
- WR: mem_wr=1 and mux13_sel=00 → DONE.
- DONE: done=1 → IDLE.
- mux13_sel is 10 in every state except WR. It never leaves the defined code set, because the MemoryData mux holds its value on an undefined select.
- start while busy: ignored and not queued. op and addr_lo are don't-care outside IDLE acceptance.
- Strobes are registered Moore outputs decoded from state only. No combinational path from any input to any output.

## Timing
- Reset values: state IDLE, counter 0, ls_ctrl=00, ss_ctrl=00, mux13_sel=10. All 1-bit outputs are 0.
- Cycle counts: accept edge = cycle 0; done is high in cycle N.
  - lw/lh/lb: N = MEM_WAIT+3. mem_rd is high in cycles 1..MEM_WAIT.
  - sw: N = 2. mem_wr is high in cycle 1 only.
  - sh/sb: N = MEM_WAIT+3. mem_wr is high in cycle MEM_WAIT+2.
  - illegal op: N = 1.
- Back-to-back: start may be asserted in the DONE cycle but is only accepted on the following IDLE cycle. Minimum gap between accepts is N+1 cycles.
- Reset mid-operation:
  - asynchronous return to IDLE
  - every strobe drops immediately
  - any write in progress is abandoned
  - no done pulse

## Configuration
- MEM_CTRL_MISALIGN_EN defined:
  - Faults: lw/sw with addr_lo≠00, or lh/sh with addr_lo[0]=1.
  - On a fault at accept: go directly to DONE with no memory, mdr_ld or reg_wr activity. misalign=1 together with done.
- MEM_CTRL_MISALIGN_EN undefined:
  - addr_lo is ignored.
  - The misalign port is kept and tied to 0.

## Test plan
- Reset: assert reset mid-RD of lw (MEM_WAIT=2) → all strobes 0 asynchronously, mux13_sel=10, busy=0, no done.
- lw: start with op=000 → mem_rd in cycles 1–2, mdr_ld in cycle 3, reg_wr in cycle 4 with ls_ctrl=00, done in cycle 5.
- sb: start with op=101 → mem_rd in cycles 1–2, mdr_ld in cycle 3, mem_wr in cycle 4 with ss_ctrl=10 and mux13_sel=00, done in cycle 5. reg_wr is never high.
- sw, then a second start during busy: op=011 → mem_wr in cycle 1 only, done in cycle 2. A start held in cycles 1–2 is ignored; a start in cycle 3 is accepted.
- Illegal op 111 → done in cycle 1; mem_rd, mem_wr, mdr_ld and reg_wr stay 0; mux13_sel is never 11.
- With MEM_CTRL_MISALIGN_EN: lh with addr_lo=01 → done and misalign in cycle 1, no strobes. Without the macro, the same stimulus behaves as a normal lh, done in cycle 5.

Source files
------------

// File: rtl/mem_access_ctrl_if.sv
// Handshake and strobe bundle between the main control FSM / datapath (master)
// and the load/store sequencer (slave).
interface mem_access_ctrl_if;
    logic       start;
    logic [2:0] op;
    logic [1:0] addr_lo;
    logic       mem_rd;
    logic       mem_wr;
    logic       mdr_ld;
    logic       reg_wr;
    logic [1:0] ls_ctrl;
    logic [1:0] ss_ctrl;
    logic [1:0] mux13_sel;
    logic       busy;
    logic       done;
    logic       misalign;

    modport master (
        output start, op, addr_lo,
        input  mem_rd, mem_wr, mdr_ld, reg_wr, ls_ctrl, ss_ctrl, mux13_sel,
               busy, done, misalign
    );

    modport slave (
        input  start, op, addr_lo,
        output mem_rd, mem_wr, mdr_ld, reg_wr, ls_ctrl, ss_ctrl, mux13_sel,
               busy, done, misalign
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// Load/store phase sequencer: registered Moore strobes, sub-word stores as read-modify-write.
// Optional alignment fault detection is enabled by defining MEM_CTRL_MISALIGN_EN.
module mem_access_ctrl #(
    parameter int MEM_WAIT = 2
) (
    input logic             clk,
    input logic             reset,
    mem_access_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RD, CAP, WB, WR, DONE} state_t;

    localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT - 1);

    state_t     state;
    state_t     nxt;
    logic [3:0] cnt;
    logic [2:0] op_q;
    logic       accept;
    logic       fault;

    function automatic logic [1:0] ls_of(input logic [2:0] o);
        case (o)
            3'b001:  return 2'b01;
            3'b010:  return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic logic [1:0] ss_of(input logic [2:0] o);
        case (o)
            3'b100:  return 2'b01;
            3'b101:  return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic state_t next_of(input state_t s, input logic acc, input logic flt,
                                       input logic [2:0] o_in, input logic [2:0] o_q,
                                       input logic last);
        case (s)
            IDLE: begin
                if (!acc)     return IDLE;
                else if (flt) return DONE;
                else begin
                    case (o_in)
                        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: return RD;
                        3'b011:  return WR;
                        default: return DONE;
                    endcase
                end
            end
            RD:      return last ? CAP : RD;
            CAP:     return (o_q <= 3'b010) ? WB : WR;
            WB:      return DONE;
            WR:      return DONE;
            DONE:    return IDLE;
            default: return IDLE;
        endcase
    endfunction

    assign accept = (state == IDLE) && bus.start;

`ifdef MEM_CTRL_MISALIGN_EN
    logic misalign_q;

    assign fault = (((bus.op == 3'b000) || (bus.op == 3'b011)) && (bus.addr_lo != 2'b00)) ||
                   (((bus.op == 3'b001) || (bus.op == 3'b100)) && bus.addr_lo[0]);
    assign bus.misalign = misalign_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) misalign_q <= 1'b0;
        else       misalign_q <= accept && fault;
    end
`else
    logic unused_addr;

    assign fault        = 1'b0;
    assign unused_addr  = ^bus.addr_lo;
    assign bus.misalign = 1'b0;
`endif

    assign nxt = next_of(state, accept, fault, bus.op, op_q, cnt == WAIT_LAST);

    // Outputs are decoded from the state being entered so they line up with it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            op_q          <= 3'b000;
            bus.ls_ctrl   <= 2'b00;
            bus.ss_ctrl   <= 2'b00;
            bus.mux13_sel <= 2'b10;
            bus.mem_rd    <= 1'b0;
            bus.mem_wr    <= 1'b0;
            bus.mdr_ld    <= 1'b0;
            bus.reg_wr    <= 1'b0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
        end else begin
            state <= nxt;
            cnt   <= ((state == RD) && (nxt == RD)) ? cnt + 4'd1 : 4'd0;
            if (accept) begin
                op_q        <= bus.op;
                bus.ls_ctrl <= ls_of(bus.op);
                bus.ss_ctrl <= ss_of(bus.op);
            end
            bus.mux13_sel <= (nxt == WR) ? 2'b00 : 2'b10;
            bus.mem_rd    <= (nxt == RD);
            bus.mem_wr    <= (nxt == WR);
            bus.mdr_ld    <= (nxt == CAP);
            bus.reg_wr    <= (nxt == WB);
            bus.busy      <= (nxt != IDLE);
            bus.done      <= (nxt == DONE);
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus queues per-cycle expected strobes,
// a negedge monitor pops and compares them.
module tb_mem_access_ctrl;
    localparam int MW = 2;

    logic clk;
    logic reset;

    mem_access_ctrl_if bus();

    mem_access_ctrl #(.MEM_WAIT(MW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic       rd;
        logic       wr;
        logic       mdr;
        logic       rw;
        logic [1:0] ls;
        logic [1:0] ss;
        logic [1:0] mux;
        logic       busy;
        logic       done;
        logic       mis;
    } ovec_t;

    typedef struct {
        int    stamp;
        ovec_t exp;
        ovec_t mask;
        string name;
    } rec_t;

    rec_t sb_q[$];
    rec_t r;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_bad = 0;
    bit   fin = 0;
    bit   end_checked = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic bit is_fault(input logic [2:0] o, input logic [1:0] a);
`ifdef MEM_CTRL_MISALIGN_EN
        return (((o == 3'd0) || (o == 3'd3)) && (a != 2'b00)) ||
               (((o == 3'd1) || (o == 3'd4)) && a[0]);
`else
        return (o == 3'd7) && (a == 2'b11) && 1'b0;
`endif
    endfunction

    function automatic int n_of(input logic [2:0] o, input logic [1:0] a);
        if (is_fault(o, a) || (o > 3'd5)) return 1;
        if (o == 3'd3) return 2;
        return MW + 3;
    endfunction

    // Expected outputs in cycle k after acceptance (k = n+1 is the idle cycle after done).
    function automatic void build(input logic [2:0] o, input logic [1:0] a, input int k,
                                  input int n, output ovec_t e, output ovec_t m);
        bit f      = is_fault(o, a);
        bit ld     = (o <= 3'd2) && !f;
        bit st_sub = ((o == 3'd4) || (o == 3'd5)) && !f;
        bit sw     = (o == 3'd3) && !f;
        e = '0;
        e.mux = 2'b10;
        m = '1;
        m.ls = 2'b00;
        m.ss = 2'b00;
        if (k > n) return;
        e.busy = 1'b1;
        if (ld) begin
            m.ls = 2'b11;
            e.ls = (o == 3'd1) ? 2'b01 : (o == 3'd2) ? 2'b10 : 2'b00;
        end
        if (sw || st_sub) begin
            m.ss = 2'b11;
            e.ss = (o == 3'd4) ? 2'b01 : (o == 3'd5) ? 2'b10 : 2'b00;
        end
        if (sw) begin
            if (k == 1) begin e.wr = 1'b1; e.mux = 2'b00; end
            if (k == 2) e.done = 1'b1;
        end else if (ld || st_sub) begin
            e.rd  = (k <= MW);
            e.mdr = (k == MW + 1);
            if (k == MW + 2) begin
                if (ld) e.rw = 1'b1;
                else begin e.wr = 1'b1; e.mux = 2'b00; end
            end
            e.done = (k == MW + 3);
        end else begin
            e.done = (k == 1);
            e.mis  = f;
        end
    endfunction

    function automatic ovec_t sample();
        ovec_t v;
        v = {bus.mem_rd, bus.mem_wr, bus.mdr_ld, bus.reg_wr, bus.ls_ctrl, bus.ss_ctrl,
             bus.mux13_sel, bus.busy, bus.done, bus.misalign};
        return v;
    endfunction

    function automatic ovec_t idle_vec();
        ovec_t v;
        v = '0;
        v.mux = 2'b10;
        return v;
    endfunction

    task automatic push(input int stamp, input ovec_t e, input ovec_t m, input string nm);
        rec_t x;
        x.stamp = stamp;
        x.exp   = e;
        x.mask  = m;
        x.name  = nm;
        sb_q.push_back(x);
    endtask

    task automatic issue(input logic [2:0] o, input logic [1:0] a, input string nm, input bit keep);
        int    n;
        ovec_t e;
        ovec_t m;
        n = n_of(o, a);
        bus.start   = 1'b1;
        bus.op      = o;
        bus.addr_lo = a;
        @(posedge clk); #1;
        if (!keep) begin
            bus.start   = 1'b0;
            bus.op      = 3'($urandom);
            bus.addr_lo = 2'($urandom);
        end
        for (int k = 1; k <= n + 1; k++) begin
            build(o, a, k, n, e, m);
            push(cyc + k - 1, e, m, $sformatf("%s_c%0d", nm, k));
        end
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        n_vec++;
        if (bus.mux13_sel == 2'b11) begin
            n_bad++;
            $display("FAIL mux13_code at cycle %0d: got %b, required not 11", cyc, bus.mux13_sel);
        end
        while ((sb_q.size() > 0) && (sb_q[0].stamp <= cyc)) begin
            r = sb_q.pop_front();
            n_vec++;
            if (r.stamp < cyc) begin
                n_bad++;
                $display("FAIL %s: record for cycle %0d left unchecked at cycle %0d", r.name, r.stamp, cyc);
            end else if (((sample() ^ r.exp) & r.mask) != '0) begin
                n_bad++;
                $display("FAIL %s: got %b, required %b (mask %b) [rd wr mdr rw ls ss mux busy done mis]",
                         r.name, sample(), r.exp, r.mask);
            end
        end
        if (fin && !end_checked) begin
            n_vec++;
            if (sb_q.size() != 0) begin
                n_bad++;
                $display("FAIL scoreboard_drain: %0d records pending, required 0", sb_q.size());
            end
            end_checked = 1'b1;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, %0d miscompares so far", n_bad);
        $fatal(1, "timeout");
    end

    initial begin
        ovec_t full;
        full = '1;
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.op      = 3'b000;
        bus.addr_lo = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        push(cyc, idle_vec(), full, "reset_state");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of a lw read phase: strobes must drop before the next edge.
        bus.start = 1'b1;
        bus.op    = 3'b000;
        @(posedge clk); #1;
        bus.start = 1'b0;
        #2 reset = 1'b1;
        push(cyc, idle_vec(), full, "async_reset");
        for (int i = 1; i <= 2; i++) push(cyc + i, idle_vec(), full, "reset_hold");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) push(cyc + i, idle_vec(), full, "post_reset_no_done");
        repeat (4) @(posedge clk);
        #1;

        issue(3'b000, 2'b00, "lw", 1'b0);
        issue(3'b001, 2'b00, "lh", 1'b0);
        issue(3'b010, 2'b11, "lb", 1'b0);
        issue(3'b011, 2'b00, "sw_b2b", 1'b1);
        issue(3'b010, 2'b01, "lb_after_b2b", 1'b0);
        issue(3'b100, 2'b10, "sh", 1'b0);
        issue(3'b101, 2'b11, "sb", 1'b0);
        issue(3'b110, 2'b00, "ill110", 1'b0);
        issue(3'b111, 2'b00, "ill111", 1'b0);
        issue(3'b001, 2'b01, "lh_a01", 1'b0);
        issue(3'b011, 2'b10, "sw_a10", 1'b0);
        issue(3'b000, 2'b10, "lw_a10", 1'b0);
        issue(3'b100, 2'b01, "sh_a01", 1'b0);
        issue(3'b101, 2'b01, "sb_a01", 1'b0);

        repeat (2) @(posedge clk);
        #1;
        fin = 1'b1;
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
